// File: rtl/log_pkg.sv
// Shared definitions for the logarithm engine.
//   - FSM state encoding
//   - default iteration count and guard-bit width
//   - fixed-point range limits for the 2.16 input format
package log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ITER_DEF  = 20;
    localparam int GUARD_DEF = 4;

    // e truncated to 2.16, and 1.0 in 2.16
    localparam logic [17:0] E_LIMIT = 18'h2B7E1;
    localparam logic [17:0] ONE_FIX = 18'h10000;

endpackage

// File: rtl/logarithm_if.sv
// Request/result bundle of the logarithm engine.
//   start      : request, level-sampled while the engine is idle
//   int_part   : 2 integer bits of the operand
//   frac_part  : 16 fraction bits of the operand
//   done       : result valid, held while the engine sits in DONE
//   err        : operand out of [1.0, e], valid with done
//   y          : ln(operand) as unsigned Q0.16
interface logarithm_if;
    logic        start;
    logic [1:0]  int_part;
    logic [15:0] frac_part;
    logic        done;
    logic        err;
    logic [15:0] y;

    modport master (output start, output int_part, output frac_part,
                    input  done,  input  err,      input  y);
    modport slave  (input  start, input  int_part, input  frac_part,
                    output done,  output err,      output y);
endinterface

// File: rtl/log_const_rom.sv
// Combinational table of ln(1 + 2^-k), k = 0..31.
//   k     : iteration index
//   lntab : round(ln(1+2^-k) * 2^(16+GUARD)), format 1.(16+GUARD)
// The table is held at 20 fraction bits and rescaled for other GUARD values.
module log_const_rom #(
    parameter int GUARD = 4
) (
    input  logic [4:0]        k,
    output logic [16+GUARD:0] lntab
);

    logic [20:0] raw_s;

    // Table lookup; entries from k = 21 upward round to zero at 20 fraction bits
    always_comb begin
        raw_s = 21'h000000;
        case (k)
            5'd0:    raw_s = 21'h0B1721;
            5'd1:    raw_s = 21'h067CC9;
            5'd2:    raw_s = 21'h0391FF;
            5'd3:    raw_s = 21'h01E270;
            5'd4:    raw_s = 21'h00F852;
            5'd5:    raw_s = 21'h007E0A;
            5'd6:    raw_s = 21'h003F81;
            5'd7:    raw_s = 21'h001FE0;
            5'd8:    raw_s = 21'h000FF8;
            5'd9:    raw_s = 21'h0007FE;
            5'd10:   raw_s = 21'h000400;
            5'd11:   raw_s = 21'h000200;
            5'd12:   raw_s = 21'h000100;
            5'd13:   raw_s = 21'h000080;
            5'd14:   raw_s = 21'h000040;
            5'd15:   raw_s = 21'h000020;
            5'd16:   raw_s = 21'h000010;
            5'd17:   raw_s = 21'h000008;
            5'd18:   raw_s = 21'h000004;
            5'd19:   raw_s = 21'h000002;
            5'd20:   raw_s = 21'h000001;
            default: raw_s = 21'h000000;
        endcase
    end

    if (GUARD == 4) begin : g_exact
        assign lntab = raw_s;
    end else if (GUARD > 4) begin : g_widen
        assign lntab = {raw_s, {(GUARD-4){1'b0}}};
    end else begin : g_narrow
        assign lntab = raw_s[20:4-GUARD];
    end

endmodule

// File: rtl/logarithm.sv
// Iterative natural logarithm by shift-add multiplicative normalisation.
// Greedily builds p = prod(1+2^-k) <= yin while summing ln(1+2^-k) into acc,
// one k per clock, then rounds acc to Q0.16.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : logarithm_if.slave (start/int_part/frac_part in, done/err/y out)
module logarithm
    import log_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    logarithm_if.slave bus
);

    localparam int            FW     = 16 + GUARD;
    localparam logic [FW+1:0] ONE_P  = {2'b01, {FW{1'b0}}};
    localparam logic [5:0]    ITER_K = 6'(ITER);

    state_t        state_r;
    logic [17:0]   yin_r;
    logic [FW+1:0] p_r;     // 2.FW running product
    logic [FW:0]   acc_r;   // 1.FW running log sum
    logic [5:0]    k_r;
    logic          done_r;
    logic          err_r;
    logic [15:0]   y_r;

    logic [FW+2:0] t_s;
    logic [FW+2:0] yin_ext_s;
    logic [FW:0]   lntab_s;
    logic [16:0]   q_s;
    logic [15:0]   q_sat_s;

    log_const_rom #(.GUARD(GUARD)) u_rom (
        .k     (k_r[4:0]),
        .lntab (lntab_s)
    );

    // Trial product, aligned operand, and rounded/saturated result
    always_comb begin
        // t can reach just under 8, so it gets one bit more than p
        t_s       = {1'b0, p_r} + ({1'b0, p_r} >> k_r);
        yin_ext_s = '0;
        yin_ext_s[FW+1:GUARD] = yin_r;
        // round-half-up on the highest guard bit
        q_s = acc_r[FW:GUARD] + {16'b0, acc_r[GUARD-1]};
        if (q_s[16]) begin
            q_sat_s = 16'hFFFF;
        end else begin
            q_sat_s = q_s[15:0];
        end
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            yin_r   <= 18'h00000;
            p_r     <= '0;
            acc_r   <= '0;
            k_r     <= 6'd0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            y_r     <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        yin_r   <= {bus.int_part, bus.frac_part};
                        p_r     <= ONE_P;
                        acc_r   <= '0;
                        k_r     <= 6'd0;
                        y_r     <= 16'h0000;
                        err_r   <= 1'b0;
                        state_r <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // k == ITER is a turnaround cycle that hands off to FIN
                    if (k_r == ITER_K) begin
                        state_r <= ST_FIN;
                    end else begin
                        if (t_s <= yin_ext_s) begin
                            p_r   <= t_s[FW+1:0];
                            acc_r <= acc_r + lntab_s;
                        end
                        k_r <= k_r + 6'd1;
                    end
                end
                ST_FIN: begin
                    if (yin_r < ONE_FIX) begin
                        y_r   <= 16'h0000;
                        err_r <= 1'b1;
                    end else if (yin_r > E_LIMIT) begin
                        y_r   <= 16'hFFFF;
                        err_r <= 1'b1;
                    end else begin
                        y_r   <= q_sat_s;
                        err_r <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // a held start must not retrigger
                    if (!bus.start) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done = done_r;
    assign bus.err  = err_r;
    assign bus.y    = y_r;

endmodule

// File: tb/tb_logarithm.sv
// Directed bench for the logarithm engine: table of operands with
// hand-derived results, plus held-start and mid-operation reset scenarios.
module tb_logarithm;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logarithm_if bus ();

    logarithm #(.ITER(20), .GUARD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rises = 0;

    always @(posedge bus.done) rises++;

    typedef struct {
        logic [1:0]  ip;
        logic [15:0] fp;
        logic [15:0] ey;
        int          tol;
        logic        eerr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        total++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Issue one request; returns edges from acceptance to done and y just after acceptance
    task automatic run_op(input logic [1:0] ip, input logic [15:0] fp, input bit hold,
                          output int lat, output int y_acc);
        @(negedge clk);
        bus.int_part  = ip;
        bus.frac_part = fp;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        y_acc = int'(bus.y);
        lat = 0;
        if (!hold) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.int_part  = 2'd3;
            bus.frac_part = 16'hFFFF;
        end
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int yacc;
        int r0;
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int yacc;
        int r0;

        vecs[0] = '{2'd1, 16'h0000, 16'h0000, 0, 1'b0};
        vecs[1] = '{2'd1, 16'h4000, 16'h3920, 0, 1'b0};
        vecs[2] = '{2'd1, 16'h8000, 16'h67CD, 0, 1'b0};
        vecs[3] = '{2'd0, 16'h8000, 16'h0000, 0, 1'b1};
        vecs[4] = '{2'd3, 16'h0000, 16'hFFFF, 0, 1'b1};
        vecs[5] = '{2'd2, 16'h0000, 16'hB172, 0, 1'b0};
        vecs[6] = '{2'd2, 16'hB7E1, 16'hFFFF, 1, 1'b0};
        vecs[7] = '{2'd2, 16'hB7E2, 16'hFFFF, 0, 1'b1};
        vecs[8] = '{2'd1, 16'h48B6, 16'h4000, 2, 1'b0};
        vecs[9] = '{2'd1, 16'h2216, 16'h2000, 2, 1'b0};

        bus.start     = 1'b0;
        bus.int_part  = 2'd0;
        bus.frac_part = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", int'(bus.done), 0, 0);
        chk("rst_err",  int'(bus.err),  0, 0);
        chk("rst_y",    int'(bus.y),    0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].ip, vecs[i].fp, 1'b0, lat, yacc);
            chk($sformatf("v%0d_clr", i), yacc, 0, 0);
            chk($sformatf("v%0d_lat", i), lat, 22, 0);
            chk($sformatf("v%0d_y", i), int'(bus.y), int'(vecs[i].ey), vecs[i].tol);
            chk($sformatf("v%0d_err", i), int'(bus.err), int'(vecs[i].eerr), 0);
            // start is already low, so done drops on the next edge and y holds
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_drop", i), int'(bus.done), 0, 0);
            chk($sformatf("v%0d_hold", i), int'(bus.y), int'(vecs[i].ey), vecs[i].tol);
        end

        // Held start: one computation only, done stays up until start falls
        r0 = rises;
        run_op(2'd1, 16'h4000, 1'b1, lat, yacc);
        chk("hold_lat", lat, 22, 0);
        repeat (17) @(posedge clk);
        #1;
        chk("hold_done", int'(bus.done), 1, 0);
        chk("hold_y", int'(bus.y), 16'h3920, 0);
        chk("hold_rises", rises - r0, 1, 0);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_drop", int'(bus.done), 0, 0);
        chk("hold_keep_y", int'(bus.y), 16'h3920, 0);

        // Reset during iteration 10 aborts immediately, no late result
        @(negedge clk);
        bus.int_part  = 2'd2;
        bus.frac_part = 16'h0000;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_done", int'(bus.done), 0, 0);
        chk("abort_y", int'(bus.y), 0, 0);
        chk("abort_err", int'(bus.err), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        r0 = rises;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_quiet", rises - r0, 0, 0);
        run_op(2'd1, 16'h8000, 1'b0, lat, yacc);
        chk("post_lat", lat, 22, 0);
        chk("post_y", int'(bus.y), 16'h67CD, 0);
        chk("post_err", int'(bus.err), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logarithm.md
Name: logarithm

Overview:
- Iterative fixed-point natural-log engine; inverse of the `exponential` block.
- Accepts `y` in the `exponential` output format: 2-bit integer plus 16-bit fraction, value range [1.0, e].
- Returns `ln(y)` as an unsigned Q0.16 fraction in [0, 1).
- Sits beside `exponential` in the Engine datapath. Exp→log loopback gives a self-check path.
- Algorithm: shift-add multiplicative normalisation. One iteration per clock, no multipliers.

Parameters:
- `ITER`, 20, number of normalisation iterations (k = 0..ITER-1). Must be ≥ 18 to meet the accuracy requirement.
- `GUARD`, 4, extra fraction bits carried internally beyond 16.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous reset, active-high.
- `start`  input  1  request. Level-sampled in IDLE.
- `int_part`  input  2  integer bits of `y`.
- `frac_part`  input  16  fraction bits of `y`.
- `done`  output  1  result valid. Held high in DONE state.
- `err`  output  1  input out of range. Valid while `done` is high.
- `y`  output  16  `ln` result, Q0.16.

Behaviour:
- Reset (async, `rst`=1): state=IDLE; `done`=0, `err`=0, `y`=16'h0000; all internal registers cleared.
  - Reset asserted mid-operation aborts immediately. No partial result appears.
- States: IDLE, CALC, FIN, DONE.
- IDLE:
  - If `start`=1 at a rising edge:
    - latch {`int_part`,`frac_part`} into `yin` (2.16);
    - set `p`=1.0 and `acc`=0 (internal width 2.(16+GUARD));
    - set `k`=0; go to CALC.
  - Inputs are not sampled in any other state.
- CALC, one iteration per edge:
  - `t` = `p` + (`p` >> `k`). Compare `t` against `yin` zero-extended to 16+GUARD fraction bits.
  - If `t` ≤ `yin`: `p`←`t` and `acc`←`acc`+`LNTAB[k]`. Otherwise both hold.
  - `k`←`k`+1. When `k`=ITER-1 has been processed, go to FIN.
- FIN, one edge:
  - Round `acc` to 16 fraction bits, round-half-up on bit GUARD-1.
  - If the rounded value ≥ 1.0, saturate to 16'hFFFF.
  - Range check on `yin`:
    - `yin` < 2.16'h1_0000 (`int_part`=0): `y`←16'h0000, `err`←1;
    - `yin` > 2.16'h2_B7E1 (e truncated): `y`←16'hFFFF, `err`←1;
    - else `err`←0.
  - Go to DONE.
- DONE:
  - `done`=1; `y` and `err` stable.
  - Go to IDLE when `start`=0. Stay in DONE while `start`=1, so a held `start` never retriggers.
  - `done` drops on the edge leaving DONE.
  - `y` and `err` hold their values until the next accepted `start`; both are cleared on that acceptance edge.
- Latency: `done` rises on the (ITER+2)th rising edge after the edge that accepted `start`, i.e. 22 for ITER=20.
  - Latency is identical for out-of-range inputs.
- Accuracy: |`y` − round(ln(`yin`)·65536)| ≤ 1 LSB for all in-range inputs.
- Width rules: `p` uses 2 integer bits. Worst-case product of (1+2^-k) is < 4.77, but `t` ≤ `yin` < 4 keeps `p` < 4, so the comparison never overflows. `acc` uses 1 integer bit.

Decomposition:
- Package `log_pkg` holds:
  - state encoding constants;
  - `ITER`/`GUARD` defaults;
  - `E_LIMIT` = 18'h2B7E1;
  - `ONE_FIX` = 18'h10000.
- Sub-module `log_const_rom`: combinational ROM indexed by `k`. It returns `LNTAB[k]` = round(ln(1+2^-k)·2^(16+GUARD)), width 1.(16+GUARD).
  - `LNTAB[0]` = ln 2.
  - Table generated for k = 0..31. Entries with k ≥ ITER are unused.

Test Plan:
- Reset then `start` with `int_part`=1, `frac_part`=16'h0000 (1.0) → `done` after 22 edges; `y`=16'h0000, `err`=0.
- `y` = 2.0 (`int_part`=2, `frac_part`=0) → `y`=16'hB172 (±1), `err`=0.
- `y` = 1.25 (1, 16'h4000) → `y`=16'h3920 (±1). `y` = 1.5 (1, 16'h8000) → `y`=16'h67CD (±1).
- Out of range: (0, 16'h8000) → `y`=16'h0000, `err`=1. (3, 16'h0000) → `y`=16'hFFFF, `err`=1. Both at latency 22.
- Handshake: hold `start` high 40 cycles → exactly one computation; `done` stays high until `start` falls, then drops next edge. Assert `rst` at CALC iteration 10 → `done`=0, `y`=0 immediately. A fresh `start` then completes normally.
- Loopback: `exponential` output for x = 0.25 and 0.125 fed to `logarithm` → `y` = 16'h4000 and 16'h2000, each ±2 LSB.
